// File: rtl/multi_issue_control_unit.sv
// Superscalar decode control: per-lane one-hot decode with UBRANCH squash,
// buffered in a DEPTH-entry bundle FIFO, plus a running count of delivered lanes.
module multi_issue_control_unit #(
  parameter int LANES = 2,
  parameter int DEPTH = 2,
  parameter int CNTW  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*4-1:0]    in_opcode,
  input  logic [LANES-1:0]      in_lane_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*16-1:0]   out_ctrl,
  output logic [LANES-1:0]      out_wb,
  output logic [LANES-1:0]      out_lane_valid,
  output logic [LANES-1:0]      out_illegal,
  output logic [CNTW-1:0]       decode_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]        wptr, rptr;
  logic [AW:0]          occ;
  logic [LANES*16-1:0]  mem_ctrl [DEPTH];
  logic [LANES-1:0]     mem_wb   [DEPTH];
  logic [LANES-1:0]     mem_lv   [DEPTH];
  logic [LANES-1:0]     mem_ill  [DEPTH];

  logic [LANES*16-1:0]  dec_ctrl;
  logic [LANES-1:0]     dec_wb, dec_lv, dec_ill;
  logic                 squash;
  logic [3:0]           op;
  logic                 push, pop;
  logic [CNTW-1:0]      head_cnt;

  // Handshake: a transfer happens on an edge where valid and ready are both 1;
  // ready/valid come only from registered state, reset and flush, and a full
  // FIFO refuses input even when the head is being popped in the same cycle.
  assign in_ready  = reset & ~flush & (occ != FULL);
  assign out_valid = (occ != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready & reset & ~flush;

  always_comb begin
    dec_ctrl = '0;
    dec_wb   = '0;
    dec_lv   = '0;
    dec_ill  = '0;
    squash   = 1'b0;
    op       = '0;
    for (int i = 0; i < LANES; i++) begin
      op = in_opcode[4*i +: 4];
      if (in_lane_valid[i] && !squash) begin
        dec_lv[i] = 1'b1;
        if (op == 4'hF) begin
          dec_ill[i] = 1'b1;
        end else begin
          dec_ctrl[16*i +: 16] = 16'(1) << op;
          dec_wb[i] = (op <= 4'd3) || ((op >= 4'd6) && (op <= 4'd11));
        end
      end
      // Only an unconditional branch kills the younger lanes of the bundle.
      if (in_lane_valid[i] && (op == 4'hC)) squash = 1'b1;
    end
  end

  always_comb begin
    out_ctrl       = '0;
    out_wb         = '0;
    out_lane_valid = '0;
    out_illegal    = '0;
    if (out_valid) begin
      out_ctrl       = mem_ctrl[rptr];
      out_wb         = mem_wb[rptr];
      out_lane_valid = mem_lv[rptr];
      out_illegal    = mem_ill[rptr];
    end
  end

  always_comb begin
    head_cnt = '0;
    for (int i = 0; i < LANES; i++) head_cnt = head_cnt + CNTW'(out_lane_valid[i]);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ctrl[wptr] <= dec_ctrl;
      mem_wb[wptr]   <= dec_wb;
      mem_lv[wptr]   <= dec_lv;
      mem_ill[wptr]  <= dec_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr         <= '0;
      rptr         <= '0;
      occ          <= '0;
      decode_count <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr         <= rptr + 1'b1;
        decode_count <= decode_count + head_cnt;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_issue_control_unit.sv
// Bench for multi_issue_control_unit: directed spec scenarios plus random
// traffic, checked by a negedge monitor against a queue-based reference model.
module tb_multi_issue_control_unit;
  localparam int LANES = 2;
  localparam int DEPTH = 2;
  localparam int CNTW  = 32;
  localparam int EW    = LANES*19;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [LANES*4-1:0]  in_opcode = '0;
  logic [LANES-1:0]    in_lane_valid = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [LANES*16-1:0] out_ctrl;
  logic [LANES-1:0]    out_wb, out_lane_valid, out_illegal;
  logic [CNTW-1:0]     decode_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0]   exp_q[$];
  logic [CNTW-1:0] exp_count = '0;
  logic [EW-1:0]   head;
  logic [LANES-1:0] head_lv;
  logic            exp_ready;

  multi_issue_control_unit #(.LANES(LANES), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_lane_valid(in_lane_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_wb(out_wb),
    .out_lane_valid(out_lane_valid), .out_illegal(out_illegal),
    .decode_count(decode_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the opcode table: writeback mask by opcode, and
  // every lane after the first valid UBRANCH is dropped.
  function automatic logic [EW-1:0] model(input logic [LANES*4-1:0] ops,
                                          input logic [LANES-1:0] lvin);
    logic [LANES*16-1:0] c = '0;
    logic [LANES-1:0] w = '0, v = '0, il = '0;
    logic [15:0] wb_tab = 16'h0FCF;
    int first_br = LANES;
    for (int i = 0; i < LANES; i++)
      if (lvin[i] && ops[4*i +: 4] == 4'hC && first_br == LANES) first_br = i;
    for (int i = 0; i < LANES; i++) begin
      int opv;
      opv = int'(ops[4*i +: 4]);
      if (lvin[i] && i <= first_br) begin
        v[i] = 1'b1;
        if (opv == 15) il[i] = 1'b1;
        else begin
          c[16*i + opv] = 1'b1;
          w[i] = wb_tab[opv];
        end
      end
    end
    return {c, w, v, il};
  endfunction

  always @(negedge clk) begin
    exp_ready = reset && !flush && (exp_q.size() != DEPTH);
    check("decode_count", decode_count, exp_count);
    check("out_valid", out_valid, exp_q.size() != 0);
    check("in_ready", in_ready, exp_ready);
    if (!reset) begin
      exp_q.delete();
      exp_count = '0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        check("head", {out_ctrl, out_wb, out_lane_valid, out_illegal}, head);
        if (out_ready) begin
          exp_q.delete(0);
          head_lv = head[2*LANES-1:LANES];
          exp_count = exp_count + CNTW'($countones(head_lv));
        end
      end else begin
        check("idle_zero", {out_ctrl, out_wb, out_lane_valid, out_illegal}, 64'd0);
      end
      if (in_valid && exp_ready) exp_q.push_back(model(in_opcode, in_lane_valid));
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [LANES*4-1:0] ops, input logic [LANES-1:0] lv);
    in_valid = 1'b1;
    in_opcode = ops;
    in_lane_valid = lv;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (t > 200) begin
        check("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_head(input string name, input logic [31:0] c, input logic [1:0] w,
                             input logic [1:0] v, input logic [1:0] il);
    check({name, "_valid"}, out_valid, 1);
    check(name, {out_ctrl, out_wb, out_lane_valid, out_illegal}, {c, w, v, il});
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #100000;
    check("watchdog", 64'd0, 64'd1);
    summary();
    $finish;
  end

  initial begin
    in_valid = 1'b1;
    in_opcode = 8'h40;
    in_lane_valid = 2'b11;
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_count", decode_count, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);

    @(posedge clk); #1;
    send(8'h40, 2'b11);
    @(negedge clk);
    expect_head("basic", 32'h0010_0001, 2'b01, 2'b11, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    check("basic_count", decode_count, 2);

    @(posedge clk); #1;
    send(8'h0C, 2'b11);
    @(negedge clk);
    expect_head("squash_ub", 32'h0000_1000, 2'b00, 2'b01, 2'b00);
    @(posedge clk); #1;
    send(8'h0D, 2'b11);
    @(negedge clk);
    expect_head("no_squash_beq", 32'h0001_2000, 2'b10, 2'b11, 2'b00);
    @(posedge clk); #1;
    send(8'h2F, 2'b11);
    @(negedge clk);
    expect_head("illegal", 32'h0004_0000, 2'b10, 2'b11, 2'b01);
    @(posedge clk); #1;
    @(negedge clk);
    check("illegal_count", decode_count, 7);

    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'h21, 2'b11);
    send(8'h43, 2'b10);
    fork
      send(8'h65, 2'b01);
      begin
        @(negedge clk);
        check("bp_full_in_ready", in_ready, 0);
        check("bp_full_out_valid", out_valid, 1);
        @(negedge clk);
        check("bp_hold_in_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_count", decode_count, 11);

    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'h10, 2'b11);
    send(8'h10, 2'b11);
    flush = 1'b1;
    in_valid = 1'b1;
    in_opcode = 8'h33;
    in_lane_valid = 2'b11;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready_after", in_ready, 1);
    check("flush_count_kept", decode_count, 11);

    repeat (400) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      in_opcode = (LANES*4)'($urandom);
      in_lane_valid = LANES'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    summary();
    $finish;
  end
endmodule
